voice_dds_scheduler: RTL and testbench
======================================

# voice_dds_scheduler

Time-multiplexes one shared note/pitch-to-phase-increment converter (7-bit NOTE, 14-bit PITCH, 32-bit registered ADDER) across a bank of polyphonic voices. On each scan it snapshots all voice notes and the channel pitch-wheel value, presents them to the converter one voice per cycle, and collects the results into shadow registers. It then commits all per-voice DDS phase increments in a single cycle, so the oscillators never see a partially updated chord. It sits between the MIDI voice allocator and the DDS oscillator bank.

## Interface
- VOICES, 8: number of voices; 2..16.
- CONV_LAT, 1: converter latency in clocks from NOTE/PITCH change to ADDER valid; 1..4.

- CLK  in  1  system clock.
- RESET  in  1  synchronous, active-high reset.
- NOTES  in  7*VOICES  voice k note at [7k+6:7k].
- PITCH  in  14  pitch wheel; 8192 = centre.
- START  in  1  single-cycle scan request.
- CONV_NOTE  out  7  registered; to converter NOTE.
- CONV_PITCH  out  14  registered; to converter PITCH.
- CONV_ADDER  in  32  from converter ADDER.
- ADDERS  out  32*VOICES  committed increments; voice k at [32k+31:32k].
- BUSY  out  1  high from the cycle after an accepted START until the commit cycle, inclusive.
- DONE  out  1  one-cycle pulse in the commit cycle.

## Operation
- FSM states: IDLE, SCAN, DRAIN, COMMIT.
- IDLE: a START sampled high, or a pending request, loads snapshot registers (all NOTES, PITCH), clears the voice index, and enters SCAN.
- SCAN: CONV_NOTE = snapshot note[idx], CONV_PITCH = snapshot PITCH; idx increments each cycle. After idx = VOICES-1 the FSM enters DRAIN.
- Capture pipeline: a valid/index shift register of depth CONV_LAT follows each issued voice. When its output is valid, CONV_ADDER is written to shadow[index].
- DRAIN: lasts CONV_LAT cycles, then the FSM enters COMMIT.
- COMMIT (one cycle): ADDERS <= all shadow registers at once; DONE = 1. The FSM returns to IDLE, or goes directly to SCAN with a fresh snapshot if a request is pending.
- START while BUSY: sets a single pending flag. Multiple STARTs collapse into one request. The flag clears when the next scan begins.
- NOTES/PITCH changes mid-scan: ignored by the current scan, because it uses the snapshot.
- Idle outputs: CONV_NOTE/CONV_PITCH hold their last values; ADDERS holds.
- Reset: applies in any state, including mid-scan. Reset values:
  - FSM = IDLE; BUSY = 0; DONE = 0; pending = 0.
  - ADDERS = 0; shadow = 0; CONV_NOTE = 0; CONV_PITCH = 8192.
  - The capture pipeline is flushed, and no commit follows a reset.
- Widths: idx is $clog2(VOICES) bits and never exceeds VOICES-1. No arithmetic is done on increments; they pass through unchanged.

## Timing
- START high in cycle 0 → snapshot at the end of cycle 0. Voice k appears on CONV_NOTE in cycle 1+k.
- Voice k is captured at the end of cycle 1+k+CONV_LAT.
- ADDERS update and DONE are visible in cycle VOICES+CONV_LAT+1. Defaults: START-to-DONE = 10 cycles.
- Back-to-back operation (pending set, or START high in the COMMIT cycle): the next scan's voice 0 appears in the cycle after COMMIT. Scan period = VOICES+CONV_LAT+1 cycles.
- START high in the COMMIT cycle counts as pending. It is not lost and does not cause a double scan.

## Configuration
- VOICE_DDS_SCHED_AUTOSCAN_EN defined: in IDLE, any difference between the live NOTES/PITCH and the last snapshot raises an internal request, equivalent to START. Outputs therefore track the inputs with no host involvement. A change that occurs while BUSY sets the pending flag.
- Macro undefined: scans start only from START. The comparators are not built.

## Test plan
- Reset: assert RESET for 2 cycles mid-scan → ADDERS=0, BUSY=0, DONE=0, CONV_PITCH=8192; no DONE pulse afterwards.
- Single scan, defaults, real converter: all notes 60, PITCH=8192, START pulse → DONE exactly 10 cycles later; every ADDERS slot = 11237; BUSY high for cycles 1..10.
- Per-voice mapping: voice k note = 57+k (k = 0..7), PITCH=8192 → slot 0 = 9449, slot 3 = 11237, slot 7 = 14157. All slots change in the same cycle.
- Snapshot isolation: change NOTES to all 69 during cycle 3 of a scan → that scan commits the old values. A subsequent START commits 18898 in every slot.
- Pending collapse: three STARTs while BUSY plus one in the COMMIT cycle → exactly one extra scan, which begins immediately after COMMIT; exactly two DONE pulses total.
- Autoscan (macro defined): with the block idle, change PITCH from 8192 to 8193 → a scan starts without START; DONE follows 10 cycles later. No further scans occur while inputs are stable.

Source files
------------

// File: rtl/voice_dds_scheduler.sv
// rtl/voice_dds_scheduler.sv - shares one note/pitch-to-increment converter across VOICES and commits all DDS increments at once
// Optional build macro: VOICE_DDS_SCHED_AUTOSCAN_EN (rescan automatically whenever live NOTES/PITCH differ from the last snapshot)
module voice_dds_scheduler #(
    parameter int VOICES   = 8,
    parameter int CONV_LAT = 1
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [7*VOICES-1:0]   notes_i,
    input  logic [13:0]           pitch_i,
    input  logic                  start_i,
    output logic [6:0]            conv_note_o,
    output logic [13:0]           conv_pitch_o,
    input  logic [31:0]           conv_adder_i,
    output logic [32*VOICES-1:0]  adders_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int          IW           = $clog2(VOICES);
    localparam int          DW           = 3;
    localparam logic [13:0] PITCH_CENTRE = 14'd8192;

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_COMMIT} state_t;

    state_t                 state_q;
    logic [IW-1:0]          idx_q;
    logic [DW-1:0]          drain_q;
    logic                   pend_q;
    logic                   busy_q;
    logic                   done_q;
    logic [7*VOICES-1:0]    snap_notes_q;
    logic [6:0]             conv_note_q;
    // conv_pitch_q doubles as the pitch snapshot: it is loaded once per scan and held until the next one
    logic [13:0]            conv_pitch_q;
    logic [32*VOICES-1:0]   adders_q;
    logic [31:0]            shadow_q [VOICES];
    logic [31:0]            shadow_d [VOICES];
    logic                   pipe_vld_q [CONV_LAT];
    logic [IW-1:0]          pipe_idx_q [CONV_LAT];

    logic                   req_d;
    logic                   launch_d;
    logic [IW-1:0]          next_idx_d;
    logic [6:0]             next_note_d;
    logic [32*VOICES-1:0]   commit_d;
    logic                   cap_vld;
    logic [IW-1:0]          cap_idx;

`ifdef VOICE_DDS_SCHED_AUTOSCAN_EN
    logic auto_req;
    assign auto_req = (notes_i != snap_notes_q) || (pitch_i != conv_pitch_q);
    assign req_d    = start_i | auto_req;
`else
    assign req_d    = start_i;
`endif

    // A new scan begins from IDLE on a request, or straight out of COMMIT when one is waiting
    assign launch_d = ((state_q == S_IDLE) && req_d) ||
                      ((state_q == S_COMMIT) && (req_d || pend_q));

    assign cap_vld    = pipe_vld_q[CONV_LAT-1];
    assign cap_idx    = pipe_idx_q[CONV_LAT-1];
    assign next_idx_d = idx_q + IW'(1);

    // Select the snapshot note for the voice presented on the following cycle
    always_comb begin
        next_note_d = '0;
        for (int k = 0; k < VOICES; k++) begin
            if (next_idx_d == IW'(k)) begin
                next_note_d = snap_notes_q[7*k +: 7];
            end
        end
    end

    // Shadow next-state: the converter result lands in the slot of the voice it belongs to
    always_comb begin
        for (int k = 0; k < VOICES; k++) begin
            shadow_d[k] = shadow_q[k];
            if (cap_vld && (cap_idx == IW'(k))) begin
                shadow_d[k] = conv_adder_i;
            end
        end
    end

    // Commit image includes the capture happening on the same edge (last voice finishes in the final DRAIN cycle)
    always_comb begin
        commit_d = '0;
        for (int k = 0; k < VOICES; k++) begin
            commit_d[32*k +: 32] = shadow_d[k];
        end
    end

    // Valid/index delay line that tracks each issued voice through the converter latency
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int s = 0; s < CONV_LAT; s++) begin
                pipe_vld_q[s] <= 1'b0;
                pipe_idx_q[s] <= '0;
            end
        end else begin
            pipe_vld_q[0] <= (state_q == S_SCAN);
            pipe_idx_q[0] <= idx_q;
            for (int s = 1; s < CONV_LAT; s++) begin
                pipe_vld_q[s] <= pipe_vld_q[s-1];
                pipe_idx_q[s] <= pipe_idx_q[s-1];
            end
        end
    end

    // Shadow registers collect converter results for the scan in progress
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int k = 0; k < VOICES; k++) begin
                shadow_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < VOICES; k++) begin
                shadow_q[k] <= shadow_d[k];
            end
        end
    end

    // Scan sequencer with registered converter drive, busy/done and committed increments
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            drain_q      <= '0;
            pend_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            snap_notes_q <= '0;
            conv_note_q  <= '0;
            conv_pitch_q <= PITCH_CENTRE;
            adders_q     <= '0;
        end else begin
            done_q <= 1'b0;
            if (launch_d) begin
                state_q      <= S_SCAN;
                idx_q        <= '0;
                pend_q       <= 1'b0;
                busy_q       <= 1'b1;
                snap_notes_q <= notes_i;
                conv_note_q  <= notes_i[6:0];
                conv_pitch_q <= pitch_i;
            end else begin
                case (state_q)
                    S_SCAN: begin
                        if (req_d) begin
                            pend_q <= 1'b1;
                        end
                        if (idx_q == IW'(VOICES-1)) begin
                            state_q <= S_DRAIN;
                            drain_q <= '0;
                        end else begin
                            idx_q       <= next_idx_d;
                            conv_note_q <= next_note_d;
                        end
                    end
                    S_DRAIN: begin
                        if (req_d) begin
                            pend_q <= 1'b1;
                        end
                        if (drain_q == DW'(CONV_LAT-1)) begin
                            state_q  <= S_COMMIT;
                            adders_q <= commit_d;
                            done_q   <= 1'b1;
                        end else begin
                            drain_q <= drain_q + DW'(1);
                        end
                    end
                    S_COMMIT: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign conv_note_o  = conv_note_q;
    assign conv_pitch_o = conv_pitch_q;
    assign adders_o     = adders_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;

endmodule

// File: tb/tb_voice_dds_scheduler.sv
// tb/tb_voice_dds_scheduler.sv - self-checking bench for voice_dds_scheduler with a behavioural scan model
module tb_voice_dds_scheduler;

    localparam int VOICES   = 8;
    localparam int CONV_LAT = 1;
    localparam int SCAN_LEN = VOICES + CONV_LAT + 1;

    logic                  clk = 1'b0;
    logic                  reset_i = 1'b1;
    logic                  start_i = 1'b0;
    logic [7*VOICES-1:0]   notes_i = '0;
    logic [13:0]           pitch_i = 14'd8192;
    logic [6:0]            conv_note_o;
    logic [13:0]           conv_pitch_o;
    logic [31:0]           conv_adder = '0;
    logic [32*VOICES-1:0]  adders_o;
    logic                  busy_o;
    logic                  done_o;

    int n_pass  = 0;
    int n_total = 0;

    voice_dds_scheduler #(.VOICES(VOICES), .CONV_LAT(CONV_LAT)) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .notes_i      (notes_i),
        .pitch_i      (pitch_i),
        .start_i      (start_i),
        .conv_note_o  (conv_note_o),
        .conv_pitch_o (conv_pitch_o),
        .conv_adder_i (conv_adder),
        .adders_o     (adders_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    always #5 clk = ~clk;

    // Equal-tempered converter, 100 MHz sample clock, +/-2 semitone wheel
    function automatic logic [31:0] conv_fn(input logic [6:0] n, input logic [13:0] p);
        real semis;
        real inc;
        semis = real'(int'(n) - 69) + real'(int'(p) - 8192) * 2.0 / 8192.0;
        inc   = 440.0 * (2.0 ** (semis / 12.0)) * 4294967296.0 / 1.0e8;
        return 32'($rtoi(inc + 0.5));
    endfunction

    // Registered converter, one clock of latency
    always @(posedge clk) conv_adder <= conv_fn(conv_note_o, conv_pitch_o);

    function automatic logic [7*VOICES-1:0] all_notes(input int n);
        logic [7*VOICES-1:0] v;
        for (int k = 0; k < VOICES; k++) v[7*k +: 7] = 7'(n);
        return v;
    endfunction

    function automatic logic [31:0] slot(input int k);
        return adders_o[32*k +: 32];
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h required %0h", name, act, exp);
        else n_pass++;
    endtask

    // Model state: scan timing expressed as commit cycle numbers
    int                   cyc       = 0;
    bit                   armed     = 0;
    bit                   m_busy    = 0;
    bit                   m_pend    = 0;
    int                   m_commit  = -1;
    logic [255:0]         m_adders  = '0;
    logic [255:0]         m_next    = '0;
    logic [7*VOICES-1:0]  m_snap_n  = '0;
    logic [13:0]          m_snap_p  = 14'd8192;
    int                   done_seen = 0;
    int                   last_done = 0;
    int                   prev_done = 0;

    task automatic take_snapshot();
        m_snap_n = notes_i;
        m_snap_p = pitch_i;
        m_next   = '0;
        for (int k = 0; k < VOICES; k++) m_next[32*k +: 32] = conv_fn(notes_i[7*k +: 7], pitch_i);
        m_busy   = 1;
        m_pend   = 0;
        m_commit = cyc + SCAN_LEN;
    endtask

    task automatic model_step();
        bit req;
        bit exp_done;
        if (armed) begin
            exp_done = m_busy && (cyc == m_commit);
            if (exp_done) m_adders = m_next;
            chk("done", 256'(done_o), 256'(exp_done));
            chk("busy", 256'(busy_o), 256'(m_busy));
            chk("adders", 256'(adders_o), m_adders);
            if (done_o) begin
                done_seen++;
                prev_done = last_done;
                last_done = cyc;
            end
        end
        if (reset_i) begin
            m_busy = 0; m_pend = 0; m_commit = -1; m_adders = '0;
            m_snap_n = '0; m_snap_p = 14'd8192;
            armed = 1;
        end else begin
            req = start_i;
`ifdef VOICE_DDS_SCHED_AUTOSCAN_EN
            if ((notes_i != m_snap_n) || (pitch_i != m_snap_p)) req = 1;
`endif
            if (!m_busy) begin
                if (req) take_snapshot();
            end else if (cyc == m_commit) begin
                if (req || m_pend) take_snapshot();
                else m_busy = 0;
            end else if (req) begin
                m_pend = 1;
            end
        end
        cyc++;
    endtask

    task automatic tick();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int n);
        n = 1;
        while (!done_o && n < 60) begin
            tick();
            n++;
        end
    endtask

    task automatic pulse_and_wait(output int n);
        start_i = 1;
        tick();
        start_i = 0;
        wait_done(n);
    endtask

    int n;
    int base;

    initial begin
        notes_i = all_notes(60);
        pitch_i = 14'd8192;
        reset_i = 1;
        tick();
        tick();
        chk("reset_adders", 256'(adders_o), 256'(0));
        chk("reset_busy", 256'(busy_o), 256'(0));
        chk("reset_done", 256'(done_o), 256'(0));
        chk("reset_pitch", 256'(conv_pitch_o), 256'(8192));
        chk("reset_note", 256'(conv_note_o), 256'(0));
        reset_i = 0;

`ifdef VOICE_DDS_SCHED_AUTOSCAN_EN
        tick();
        wait_done(n);
        chk("auto_first_scan", 256'(done_o), 256'(1));
        repeat (5) tick();
        base = done_seen;
        repeat (20) tick();
        chk("auto_stable_quiet", 256'(done_seen - base), 256'(0));
        pitch_i = 14'd8193;
        tick();
        wait_done(n);
        chk("auto_latency", 256'(n), 256'(SCAN_LEN));
        base = done_seen;
        repeat (30) tick();
        chk("auto_no_rescan", 256'(done_seen - base), 256'(0));
        chk("auto_slot0", 256'(slot(0)), 256'(conv_fn(7'd60, 14'd8193)));
`else
        tick();
        pulse_and_wait(n);
        chk("start_to_done", 256'(n), 256'(10));
        for (int k = 0; k < VOICES; k++) chk("single_slot", 256'(slot(k)), 256'(11237));
        repeat (3) tick();

        for (int k = 0; k < VOICES; k++) notes_i[7*k +: 7] = 7'(57 + k);
        pulse_and_wait(n);
        chk("map_latency", 256'(n), 256'(10));
        chk("map_slot0", 256'(slot(0)), 256'(9449));
        chk("map_slot3", 256'(slot(3)), 256'(11237));
        chk("map_slot7", 256'(slot(7)), 256'(14157));
        repeat (3) tick();

        notes_i = all_notes(60);
        start_i = 1;
        tick();
        start_i = 0;
        tick();
        tick();
        notes_i = all_notes(69);
        wait_done(n);
        for (int k = 0; k < VOICES; k++) chk("isolate_old", 256'(slot(k)), 256'(11237));
        repeat (3) tick();
        pulse_and_wait(n);
        for (int k = 0; k < VOICES; k++) chk("isolate_new", 256'(slot(k)), 256'(18898));
        repeat (3) tick();

        base = done_seen;
        start_i = 1;
        for (int c = 1; c <= 30; c++) begin
            tick();
            start_i = (c == 2) || (c == 4) || (c == 6) || (c == 10);
        end
        start_i = 0;
        repeat (5) tick();
        chk("pend_dones", 256'(done_seen - base), 256'(2));
        chk("pend_period", 256'(last_done - prev_done), 256'(10));

        notes_i = all_notes(57);
        start_i = 1;
        tick();
        start_i = 0;
        repeat (3) tick();
        reset_i = 1;
        tick();
        tick();
        reset_i = 0;
        chk("midreset_adders", 256'(adders_o), 256'(0));
        chk("midreset_busy", 256'(busy_o), 256'(0));
        chk("midreset_done", 256'(done_o), 256'(0));
        chk("midreset_pitch", 256'(conv_pitch_o), 256'(8192));
        base = done_seen;
        repeat (25) tick();
        chk("midreset_no_done", 256'(done_seen - base), 256'(0));
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
